// File: rtl/chunked_add_sub.sv
// chunked_add_sub: multi-cycle adder/subtractor for the ALU's multi-cycle path.
// A WIDTH-bit add or subtract is performed CHUNK bits per clock through a
// rippled carry register, and the result is reported with cout/ovf/zero/neg flags.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   start  request, sampled only while busy=0
//   sub    0: A+B+cin, 1: A-B (cin ignored)
//   cin    carry-in for add mode
//   A, B   operands (latched on accept)
//   sum    result; chunks update during RUN, valid when done pulses
//   cout   carry out of the MSB (sub mode: 1 = no borrow)
//   ovf    signed overflow
//   zero   sum == 0
//   neg    sum[WIDTH-1]
//   busy   operation in progress
//   done   one-cycle completion pulse
module chunked_add_sub #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic             cin,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero,
   output logic             neg,
   output logic             busy,
   output logic             done
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state_reg, state_next;
   logic [WIDTH-1:0]  a_reg, b_reg;          // b_reg holds B or ~B
   logic              carry_reg;
   logic [IDXW-1:0]   idx_reg;
   logic [CHUNK-1:0]  sum_chunk_reg [NCHUNK];
   logic              cout_reg, ovf_reg, zero_reg, neg_reg;

   logic [CHUNK-1:0]  a_chunk [NCHUNK];
   logic [CHUNK-1:0]  b_chunk [NCHUNK];
   logic [WIDTH-1:0]  sum_final;             // full sum including the chunk being written now
   logic [CHUNK:0]    chunk_res;
   logic              accept, last_chunk;

   generate
      for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
         assign a_chunk[gi] = a_reg[gi*CHUNK +: CHUNK];
         assign b_chunk[gi] = b_reg[gi*CHUNK +: CHUNK];
         assign sum[gi*CHUNK +: CHUNK] = sum_chunk_reg[gi];
         // zero/neg are taken on the final edge, so the last chunk must come
         // from the adder rather than the not-yet-updated register.
         assign sum_final[gi*CHUNK +: CHUNK] =
            (idx_reg == IDXW'(gi)) ? chunk_res[CHUNK-1:0] : sum_chunk_reg[gi];
      end
   endgenerate

   assign chunk_res  = {1'b0, a_chunk[idx_reg]} + {1'b0, b_chunk[idx_reg]}
                     + {{CHUNK{1'b0}}, carry_reg};
   assign last_chunk = (idx_reg == IDXW'(NCHUNK - 1));
   // A start in the DONE cycle is accepted so operations can run back to back.
   assign accept     = start && (state_reg != RUN);

   assign cout = cout_reg;
   assign ovf  = ovf_reg;
   assign zero = zero_reg;
   assign neg  = neg_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (accept) state_next = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (last_chunk) state_next = DONE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = accept ? RUN : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_reg     <= '0;
         b_reg     <= '0;
         carry_reg <= 1'b0;
         idx_reg   <= '0;
         cout_reg  <= 1'b0;
         ovf_reg   <= 1'b0;
         zero_reg  <= 1'b0;
         neg_reg   <= 1'b0;
         for (int i = 0; i < NCHUNK; i++) begin
            sum_chunk_reg[i] <= '0;
         end
      end else if (accept) begin
         // Subtraction is A + ~B + 1: invert B here and seed the carry with 1.
         a_reg     <= A;
         b_reg     <= sub ? ~B : B;
         carry_reg <= sub ? 1'b1 : cin;
         idx_reg   <= '0;
      end else if (state_reg == RUN) begin
         sum_chunk_reg[idx_reg] <= chunk_res[CHUNK-1:0];
         carry_reg              <= chunk_res[CHUNK];
         idx_reg                <= idx_reg + IDXW'(1);
         if (last_chunk) begin
            cout_reg <= chunk_res[CHUNK];
            ovf_reg  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1])
                     && (chunk_res[CHUNK-1] != a_reg[WIDTH-1]);
            zero_reg <= (sum_final == '0);
            neg_reg  <= sum_final[WIDTH-1];
         end
      end
   end

endmodule

// File: tb/tb_chunked_add_sub.sv
// Testbench for chunked_add_sub: four instances (32/8, 32/32, 16/1, 8/4) share
// one clock and reset. Stimulus pushes reference results into per-instance
// scoreboards; a monitor pops and compares whenever an instance pulses done.
module tb_chunked_add_sub;

   typedef struct packed {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
      logic        zero;
      logic        neg;
      longint      due;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n = 1'b0;
   logic [3:0]       start_s = '0, sub_s = '0, cin_s = '0;
   logic [3:0][31:0] a_s = '0, b_s = '0;
   logic [3:0][31:0] sum_w;
   logic [3:0]       cout_w, ovf_w, zero_w, neg_w, busy_w, done_w;

   int     wid[4] = '{32, 32, 16, 8};
   int     nch[4] = '{4, 1, 16, 2};
   exp_t   score[4][32];
   exp_t   last_pushed[4];
   int     wp[4] = '{default: 0};
   int     rp[4] = '{default: 0};
   longint last_due[4] = '{default: 0};
   longint cyc = 0;
   int     checks = 0, errors = 0;
   exp_t   mon_e;

   always @(posedge clk) cyc <= cyc + 1;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_dut
         localparam int W = (gi == 0) ? 32 : (gi == 1) ? 32 : (gi == 2) ? 16 : 8;
         localparam int C = (gi == 0) ? 8  : (gi == 1) ? 32 : (gi == 2) ? 1  : 4;
         logic [W-1:0] sum_l;
         chunked_add_sub #(.WIDTH(W), .CHUNK(C)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .start (start_s[gi]),
            .sub   (sub_s[gi]),
            .cin   (cin_s[gi]),
            .A     (a_s[gi][W-1:0]),
            .B     (b_s[gi][W-1:0]),
            .sum   (sum_l),
            .cout  (cout_w[gi]),
            .ovf   (ovf_w[gi]),
            .zero  (zero_w[gi]),
            .neg   (neg_w[gi]),
            .busy  (busy_w[gi]),
            .done  (done_w[gi])
         );
         assign sum_w[gi] = 32'(sum_l);
      end
   endgenerate

   // Reference: plain integer arithmetic on unsigned and signed interpretations.
   function automatic exp_t model(int w, longint a, longint b, bit s, bit ci, longint due);
      exp_t   e;
      longint m    = longint'(1) << w;
      longint half = m / 2;
      longint r, sa, sb, sr;
      r  = s ? (a + m - b) : (a + b + longint'(ci));
      sa = (a >= half) ? a - m : a;
      sb = (b >= half) ? b - m : b;
      sr = s ? (sa - sb) : (sa + sb + longint'(ci));
      e.sum  = 32'(r % m);
      e.cout = (r >= m);
      e.ovf  = (sr >= half) || (sr < -half);
      e.zero = ((r % m) == 0);
      e.neg  = ((r % m) >= half);
      e.due  = due;
      return e;
   endfunction

   // Called at a negedge; drives one start cycle. The request is accepted
   // only if the previous operation has reached its done cycle.
   task automatic op(int k, longint a_in, longint b_in, bit s, bit ci);
      longint m = longint'(1) << wid[k];
      longint a = a_in & (m - 1);
      longint b = b_in & (m - 1);
      a_s[k] = 32'(a);
      b_s[k] = 32'(b);
      sub_s[k] = s;
      cin_s[k] = ci;
      start_s[k] = 1'b1;
      if (cyc >= last_due[k]) begin
         last_due[k] = cyc + 1 + longint'(nch[k]);
         last_pushed[k] = model(wid[k], a, b, s, ci, last_due[k]);
         score[k][wp[k] % 32] = last_pushed[k];
         wp[k]++;
      end
      @(negedge clk);
      start_s[k] = 1'b0;
      a_s[k] = $urandom;
      b_s[k] = $urandom;
      sub_s[k] = 1'($urandom);
      cin_s[k] = 1'($urandom);
   endtask

   task automatic wait_done(int k);
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (done_w[k]) break;
      end
   endtask

   task automatic check_zero(string name);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (sum_w[k] !== 32'h0 || {cout_w[k], ovf_w[k], zero_w[k], neg_w[k], busy_w[k], done_w[k]} !== 6'b0) begin
            errors++;
            $display("FAIL %s inst %0d: got sum=%h cout/ovf/zero/neg/busy/done=%b%b%b%b%b%b, required all 0",
                     name, k, sum_w[k], cout_w[k], ovf_w[k], zero_w[k], neg_w[k], busy_w[k], done_w[k]);
         end
      end
   endtask

   function automatic longint pick(int k);
      longint m = longint'(1) << wid[k];
      case ($urandom_range(0, 7))
         0: return 0;
         1: return m - 1;
         2: return m / 2;
         3: return m / 2 - 1;
         default: return longint'({$urandom, $urandom}) & (m - 1);
      endcase
   endfunction

   // Monitor
   initial begin
      forever begin
         @(negedge clk);
         for (int k = 0; k < 4; k++) begin
            if (done_w[k]) begin
               checks++;
               if (rp[k] == wp[k]) begin
                  errors++;
                  $display("FAIL unexpected_done inst %0d: got done=1 at cycle %0d, required no done", k, cyc);
               end else begin
                  mon_e = score[k][rp[k] % 32];
                  rp[k]++;
                  if (sum_w[k] !== mon_e.sum || cout_w[k] !== mon_e.cout || ovf_w[k] !== mon_e.ovf ||
                      zero_w[k] !== mon_e.zero || neg_w[k] !== mon_e.neg || cyc != mon_e.due) begin
                     errors++;
                     $display("FAIL result inst %0d: got sum=%h c=%b v=%b z=%b n=%b at cycle %0d, required sum=%h c=%b v=%b z=%b n=%b at cycle %0d",
                              k, sum_w[k], cout_w[k], ovf_w[k], zero_w[k], neg_w[k], cyc,
                              mon_e.sum, mon_e.cout, mon_e.ovf, mon_e.zero, mon_e.neg, mon_e.due);
                  end else begin
                     $display("inst %0d ok: sum=%h c=%b v=%b z=%b n=%b cycle %0d",
                              k, sum_w[k], cout_w[k], ovf_w[k], zero_w[k], neg_w[k], cyc);
                  end
               end
            end else if (rp[k] != wp[k] && cyc > score[k][rp[k] % 32].due) begin
               checks++;
               errors++;
               $display("FAIL missing_done inst %0d: got no done by cycle %0d, required done at cycle %0d",
                        k, cyc, score[k][rp[k] % 32].due);
               rp[k]++;
            end
         end
      end
   end

   initial begin
      exp_t held;

      // Reset held with start asserted: nothing may be accepted.
      start_s = '1;
      a_s[0] = 32'h1234_5678;
      b_s[0] = 32'h0000_0001;
      repeat (2) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;
      start_s = '0;
      @(negedge clk);
      check_zero("reset_start_ignored");

      // Directed cases on the default 32/8 instance.
      op(0, 64'hFFFFFFFF, 1, 1'b0, 1'b0); wait_done(0);
      op(0, 5, 7, 1'b1, 1'b0);            wait_done(0);
      op(0, 7, 5, 1'b1, 1'b0);            wait_done(0);
      op(0, 64'h7FFFFFFF, 1, 1'b0, 1'b0); wait_done(0);
      op(0, 64'h80000000, 1, 1'b1, 1'b0); wait_done(0);
      op(0, 64'hFFFFFFFE, 0, 1'b0, 1'b1); wait_done(0);
      op(0, 10, 3, 1'b1, 1'b0);           wait_done(0);

      // Start during RUN is ignored; flags hold until the final edge.
      held = last_pushed[0];
      op(0, 100, 23, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (busy_w[0] !== (cyc < last_due[0]) || {cout_w[0], ovf_w[0], zero_w[0], neg_w[0]} !==
          {held.cout, held.ovf, held.zero, held.neg}) begin
         errors++;
         $display("FAIL busy_hold: got busy=%b flags=%b%b%b%b, required busy=%b flags=%b%b%b%b",
                  busy_w[0], cout_w[0], ovf_w[0], zero_w[0], neg_w[0], (cyc < last_due[0]),
                  held.cout, held.ovf, held.zero, held.neg);
      end
      op(0, 1, 1, 1'b1, 1'b0);
      wait_done(0);

      // Start in the DONE cycle is accepted back to back.
      op(0, 64'h0F0F0F0F, 64'hF0F0F0F1, 1'b0, 1'b0);
      wait_done(0);
      op(0, 64'h00000001, 64'h00000002, 1'b1, 1'b0);
      wait_done(0);

      // Reset mid-RUN: operation discarded, no done, outputs cleared.
      op(0, 1234, 5678, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      rp[0] = wp[0];
      last_due[0] = 0;
      @(negedge clk);
      rst_n = 1'b1;
      check_zero("mid_run_reset");
      repeat (8) @(negedge clk);

      // Random sweep over all instances, including back-to-back starts.
      for (int k = 0; k < 4; k++) begin
         for (int n = 0; n < ((k == 0) ? 50 : 200); n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            op(k, pick(k), pick(k), 1'($urandom), 1'($urandom));
            wait_done(k);
         end
      end

      repeat (20) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (rp[k] != wp[k]) begin
            errors++;
            $display("FAIL drain inst %0d: got %0d results outstanding, required 0", k, wp[k] - rp[k]);
         end
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
